// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus signals of the two-port memory arbiter.
// slave: arbiter view. master: requesters plus memory model (testbench view).
interface mem_arbiter_if;
  // requester side
  logic        req0, req1;
  logic        we0, we1;
  logic [12:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        gnt0, gnt1;
  logic        ack0, ack1;
  logic [7:0]  rdata;
  logic        busy;
  // memory side
  logic [12:0] addr;
  logic        rd, wr;
  logic [7:0]  mem_wdata;
  logic        mem_oe;
  logic [7:0]  mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, ack0, ack1, rdata, busy, addr, rd, wr, mem_wdata, mem_oe
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, ack0, ack1, rdata, busy, addr, rd, wr, mem_wdata, mem_oe
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and access sequencer sharing one external memory port
// between the CPU (requester 0) and the loader/debug port (requester 1).
// Each access: SETUP (address), ACCESS (strobe, WAIT+1 cycles), DONE (ack).
// Every output is a flop; next values are derived from the next state.
module mem_arbiter #(
  parameter int WAIT = 1
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [2:0] WAIT_CNT = 3'(WAIT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  // access captured at grant; the bus is driven only from this copy
  typedef struct packed {
    logic        we;
    logic [12:0] addr;
    logic [7:0]  wdata;
  } acc_t;

  state_t     state_q, state_d;
  logic       prio_q,  prio_d;
  logic [2:0] wcnt_q,  wcnt_d;
  logic       id_q,    id_d;
  acc_t       acc_q,   acc_d;
  logic [7:0] rdata_q, rdata_d;

  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic ack0_q, ack0_d, ack1_q, ack1_d;
  logic rd_q,   rd_d,   wr_q,   wr_d;
  logic oe_q,   oe_d,   busy_q, busy_d;

  // next state, arbitration, wait counter and read capture
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    wcnt_d  = wcnt_q;
    id_d    = id_q;
    acc_d   = acc_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = SETUP;
          // contention resolved by the round-robin pointer
          id_d = (bus.req0 && bus.req1) ? prio_q : bus.req1;
          if (id_d) begin
            acc_d.we    = bus.we1;
            acc_d.addr  = bus.addr1;
            acc_d.wdata = bus.wdata1;
          end else begin
            acc_d.we    = bus.we0;
            acc_d.addr  = bus.addr0;
            acc_d.wdata = bus.wdata0;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        wcnt_d  = WAIT_CNT;
      end
      ACCESS: begin
        if (wcnt_q == 3'd0) begin
          state_d = DONE;
          // memory data sampled on the edge that ends the strobe
          if (!acc_q.we) rdata_d = bus.mem_rdata;
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        prio_d  = ~id_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // registered outputs computed from the state being entered
  always_comb begin
    busy_d = (state_d != IDLE);
    gnt0_d = busy_d && !id_d;
    gnt1_d = busy_d &&  id_d;
    rd_d   = (state_d == ACCESS) && !acc_d.we;
    wr_d   = (state_d == ACCESS) &&  acc_d.we;
    oe_d   = wr_d;
    ack0_d = (state_d == DONE) && !id_d;
    ack1_d = (state_d == DONE) &&  id_d;
  end

  // control state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      wcnt_q  <= 3'd0;
      id_q    <= 1'b0;
      acc_q   <= '0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      wcnt_q  <= wcnt_d;
      id_q    <= id_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
    end
  end

  // output flops; async reset drops strobes and grants immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      oe_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      oe_q   <= oe_d;
      busy_q <= busy_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rd        = rd_q;
  assign bus.wr        = wr_q;
  assign bus.mem_oe    = oe_q;
  assign bus.busy      = busy_q;
  assign bus.addr      = acc_q.addr;
  assign bus.mem_wdata = acc_q.wdata;
  assign bus.rdata     = rdata_q;

endmodule
